// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Decode-stage hazard controller for an in-order pipeline with no forwarding.
// It sits directly upstream of the ID/EX pipeline register and drives three
// controls:
//   - pipe_stall_out : hold the PC and the IF/ID register
//   - bubble_out     : zero every ID/EX control field (inject a NOP)
//   - idex_en_out    : enable for the ID/EX register
//
// Operation:
//   A three-entry scoreboard (EX, MEM, WB) records which destination
//   registers are still in flight. An instruction in decode that reads a
//   register still held by a live entry is a RAW hazard. Entries age out by
//   shifting one stage per unstalled cycle.
//
// Priority when several conditions are active together:
//   mem_stall_in > flush_in > hazard
//
// Parameters:
//   WB_BYPASS - 1: the register file writes before it reads, so the WB entry
//                  is never compared.
//               0: the WB entry is compared as well.
//   REG_W     - register-number width.
//
// Optional build macro:
//   HAZARD_STALL_CNT_EN - when defined, a saturating 16-bit counter of hazard
//                         stall cycles drives stall_cnt_out. When undefined,
//                         no counter is built and stall_cnt_out is tied to 0.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int WB_BYPASS = 1,
  parameter int REG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_num_in,
  input  logic             rs_vld_in,
  input  logic [REG_W-1:0] rt_num_in,
  input  logic             rt_vld_in,
  input  logic [REG_W-1:0] dst_reg_num_in,
  input  logic             RegWriteEN_in,
  input  logic             flush_in,
  input  logic             mem_stall_in,
  output logic             pipe_stall_out,
  output logic             bubble_out,
  output logic             idex_en_out,
  output logic [15:0]      stall_cnt_out
);

  // One in-flight register writer.
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] num;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, num: '0};

  sb_entry_t sb_ex;
  sb_entry_t sb_mem;
  sb_entry_t sb_wb;

  logic hazard;
  logic rs_hit;
  logic rt_hit;

  // A scoreboard entry blocks reader r only while it is live.
  function automatic logic entry_hit(input sb_entry_t e,
                                     input logic [REG_W-1:0] r);
    return e.vld && (e.num == r);
  endfunction

  // Register r is blocked by any compared scoreboard entry.
  // With WB_BYPASS=1 the register file writes before it reads, so the WB
  // entry can never cause a stale read and is excluded.
  function automatic logic reg_busy(input logic [REG_W-1:0] r,
                                    input sb_entry_t ex_e,
                                    input sb_entry_t mem_e,
                                    input sb_entry_t wb_e);
    return entry_hit(ex_e, r) || entry_hit(mem_e, r) ||
           ((WB_BYPASS == 0) && entry_hit(wb_e, r));
  endfunction

  // Hazard detection and pipeline controls.
  // These are purely combinational from the scoreboard and decode inputs.
  // r0 is treated as a normal register; it gets no special case.
  always_comb begin
    // NOTE: every signal written here receives a value on every path, so no latch is inferred.
    rs_hit = rs_vld_in && reg_busy(rs_num_in, sb_ex, sb_mem, sb_wb);
    rt_hit = rt_vld_in && reg_busy(rt_num_in, sb_ex, sb_mem, sb_wb);
    hazard = rs_hit || rt_hit;

    // A memory stall freezes the whole pipe, including ID/EX.
    idex_en_out = !mem_stall_in;

    // A flush overrides a hazard. The wrong-path instruction in decode is
    // discarded, so there is no reason to hold the front end for it.
    pipe_stall_out = mem_stall_in || (hazard && !flush_in);

    // While the pipe is held, ID/EX keeps its contents and no bubble is
    // injected. Otherwise a hazard or a flush puts a NOP into ID/EX.
    bubble_out = !mem_stall_in && (hazard || flush_in);
  end

  // Scoreboard shift register.
  //   - mem_stall_in=1: every entry holds, and any pending flush waits,
  //     because EX is frozen and the branch stays resolved.
  //   - otherwise: each entry advances one stage, and decode enters EX
  //     unless it was replaced by a bubble.
  // Admitting an instruction only when it is not bubbled means a stalled
  // instruction enters the scoreboard exactly once, when it finally issues.
  // A branch already in EX keeps its own entry, so a JAL writing r7 still
  // blocks readers of r7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so every stage shifts from pre-edge values.
      sb_ex  <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else if (!mem_stall_in) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (bubble_out) begin
        sb_ex <= SB_EMPTY;
      end else begin
        sb_ex <= '{vld: RegWriteEN_in, num: dst_reg_num_in};
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count clock edges on which decode is held purely by a RAW hazard.
  // The count saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (!mem_stall_in && hazard && !flush_in &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt_out = stall_cnt;
`else
  assign stall_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. Two instances share one set of inputs:
//   u_dut1 : WB_BYPASS=1
//   u_dut0 : WB_BYPASS=0
// Every expected value below is worked out by hand from the scoreboard
// behaviour.
//
// Build with +define+HAZARD_STALL_CNT_EN to expect live stall counts.
// Without it, the expected stall count is always 0.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rs_num;
  logic       rs_vld;
  logic [2:0] rt_num;
  logic       rt_vld;
  logic [2:0] dst_num;
  logic       we;
  logic       flush;
  logic       mem_stall;

  // Outputs of the WB_BYPASS=1 instance.
  logic        stall1;
  logic        bubble1;
  logic        en1;
  logic [15:0] cnt1;

  // Outputs of the WB_BYPASS=0 instance.
  logic        stall0;
  logic        bubble0;
  logic        en0;
  logic [15:0] cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.WB_BYPASS(1), .REG_W(3)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .rs_num_in     (rs_num),
    .rs_vld_in     (rs_vld),
    .rt_num_in     (rt_num),
    .rt_vld_in     (rt_vld),
    .dst_reg_num_in(dst_num),
    .RegWriteEN_in (we),
    .flush_in      (flush),
    .mem_stall_in  (mem_stall),
    .pipe_stall_out(stall1),
    .bubble_out    (bubble1),
    .idex_en_out   (en1),
    .stall_cnt_out (cnt1)
  );

  hazard_ctrl #(.WB_BYPASS(0), .REG_W(3)) u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .rs_num_in     (rs_num),
    .rs_vld_in     (rs_vld),
    .rt_num_in     (rt_num),
    .rt_vld_in     (rt_vld),
    .dst_reg_num_in(dst_num),
    .RegWriteEN_in (we),
    .flush_in      (flush),
    .mem_stall_in  (mem_stall),
    .pipe_stall_out(stall0),
    .bubble_out    (bubble0),
    .idex_en_out   (en0),
    .stall_cnt_out (cnt0)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected stall count: the hand-computed value when the counter is built,
  // otherwise 0.
  function automatic logic [31:0] cnt_exp(input int n);
`ifdef HAZARD_STALL_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Present one decode-stage input vector.
  task automatic drive(input logic [2:0] rs,  input logic rsv,
                       input logic [2:0] rt,  input logic rtv,
                       input logic [2:0] dst, input logic w,
                       input logic fl,        input logic ms);
    rs_num    = rs;
    rs_vld    = rsv;
    rt_num    = rt;
    rt_vld    = rtv;
    dst_num   = dst;
    we        = w;
    flush     = fl;
    mem_stall = ms;
    #1;
  endtask

  // Drive all decode inputs to their idle values.
  task automatic idle();
    drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare the three control outputs of both instances.
  // Arguments are {pipe_stall, bubble, idex_en}.
  task automatic expect_ctl(input string tag,
                            input logic [2:0] e1,
                            input logic [2:0] e0);
    check({tag, "/byp1"}, {29'd0, stall1, bubble1, en1}, {29'd0, e1});
    check({tag, "/byp0"}, {29'd0, stall0, bubble0, en0}, {29'd0, e0});
  endtask

  // Advance to just after the next rising edge, away from the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, return the inputs to idle, then release reset cleanly
  // between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // ---------------------------------------------------------------------
    // Reset state: inputs idle, so only idex_en is high.
    // ---------------------------------------------------------------------
    #2;
    expect_ctl("reset_idle", 3'b001, 3'b001);
    check("reset_cnt1", {16'd0, cnt1}, 0);
    check("reset_cnt0", {16'd0, cnt0}, 0);
    tick();
    rst = 1'b0;
    #1;

    // ---------------------------------------------------------------------
    // Independent stream: no read ever matches a compared scoreboard entry.
    // ---------------------------------------------------------------------
    // drive args: rs, rs_vld, rt, rt_vld, dst, RegWriteEN, flush, mem_stall
    drive(3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0);  // write r1, read r2/r3
    expect_ctl("indep0", 3'b001, 3'b001);
    tick();

    drive(3'd4, 1, 3'd5, 1, 3'd2, 1, 0, 0);  // EX=r1
    expect_ctl("indep1", 3'b001, 3'b001);
    tick();

    drive(3'd4, 1, 3'd3, 1, 3'd6, 1, 0, 0);  // EX=r2, MEM=r1
    expect_ctl("indep2", 3'b001, 3'b001);
    tick();

    drive(3'd7, 1, 3'd0, 1, 3'd0, 0, 0, 0);  // EX=r6, MEM=r2, WB=r1
    expect_ctl("indep3", 3'b001, 3'b001);
    tick();

    // Matching numbers, but the valid bits are low: no hazard.
    drive(3'd6, 0, 3'd2, 0, 3'd0, 0, 0, 0);  // EX=0, MEM=r6, WB=r2
    expect_ctl("vld_low", 3'b001, 3'b001);
    tick();

    // ---------------------------------------------------------------------
    // Writer r3, then a reader of r3.
    // Expected stalls: 2 with WB_BYPASS=1, 3 with WB_BYPASS=0.
    // ---------------------------------------------------------------------
    do_reset();
    drive(3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0);
    expect_ctl("r3_wr", 3'b001, 3'b001);
    tick();                                   // EX=r3

    drive(3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    expect_ctl("r3_stall1", 3'b111, 3'b111);
    tick();                                   // MEM=r3
    expect_ctl("r3_stall2", 3'b111, 3'b111);
    tick();                                   // WB=r3
    expect_ctl("r3_stall3", 3'b001, 3'b111);
    tick();                                   // r3 has fully aged out
    expect_ctl("r3_free", 3'b001, 3'b001);
    check("r3_cnt1", {16'd0, cnt1}, cnt_exp(2));
    check("r3_cnt0", {16'd0, cnt0}, cnt_exp(3));
    tick();

    // ---------------------------------------------------------------------
    // Reader of r5 blocked by EX=r5, with mem_stall held for 4 cycles.
    // ---------------------------------------------------------------------
    do_reset();
    drive(3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0);
    tick();                                   // EX=r5

    for (int i = 0; i < 4; i++) begin
      drive(3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 1);
      expect_ctl($sformatf("ms_hold%0d", i), 3'b100, 3'b100);
      tick();
    end
    check("ms_cnt_frozen", {16'd0, cnt1}, 0);

    drive(3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    expect_ctl("ms_rel1", 3'b111, 3'b111);    // EX=r5 is still held
    tick();
    expect_ctl("ms_rel2", 3'b111, 3'b111);    // MEM=r5
    tick();
    expect_ctl("ms_rel3", 3'b001, 3'b111);    // WB=r5
    tick();
    check("ms_cnt1", {16'd0, cnt1}, cnt_exp(2));
    check("ms_cnt0", {16'd0, cnt0}, cnt_exp(3));

    // ---------------------------------------------------------------------
    // Flush behaviour, including flush, hazard and mem_stall all at once.
    // ---------------------------------------------------------------------
    do_reset();
    drive(3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0);
    tick();                                   // EX=r4

    // Decode: writes r2, reads r4 (hazard), flush and mem_stall both high.
    drive(3'd0, 0, 3'd4, 1, 3'd2, 1, 1, 1);
    expect_ctl("all3", 3'b100, 3'b100);       // mem_stall dominates
    tick();                                   // all entries hold

    drive(3'd0, 0, 3'd4, 1, 3'd2, 1, 1, 0);
    expect_ctl("flush", 3'b011, 3'b011);      // flush overrides the hazard
    tick();                                   // EX=empty, MEM=r4

    // The flushed writer of r2 never entered the scoreboard.
    drive(3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    expect_ctl("post_flush_r2", 3'b001, 3'b001);
    check("flush_cnt1", {16'd0, cnt1}, 0);
    tick();                                   // WB=r4

    // r4 now sits only in WB, so only the WB_BYPASS=0 instance stalls.
    drive(3'd0, 0, 3'd4, 1, 3'd0, 0, 0, 0);
    expect_ctl("wb_only", 3'b001, 3'b111);
    tick();

    // ---------------------------------------------------------------------
    // Reset asserted during the first stall cycle of the r3 case.
    // ---------------------------------------------------------------------
    do_reset();
    drive(3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0);
    tick();                                   // EX=r3

    drive(3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0);
    expect_ctl("rst_pre", 3'b111, 3'b111);
    rst = 1'b1;
    #1;
    expect_ctl("rst_async", 3'b001, 3'b001);  // scoreboard cleared at once
    tick();
    rst = 1'b0;
    #1;
    expect_ctl("rst_after", 3'b001, 3'b001);
    check("rst_cnt1", {16'd0, cnt1}, 0);
    check("rst_cnt0", {16'd0, cnt0}, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Decode-stage hazard controller that sits directly upstream of the ID/EX pipeline register and drives its enable and bubble-injection controls.
- Holds a 3-entry scoreboard of in-flight register writers (EX, MEM, WB); the pipeline has no forwarding.
- Stalls PC and IF/ID and inserts a NOP into ID/EX on a RAW hazard or a taken-branch flush.
- Freezes the scoreboard when the memory stage stalls.

Parameters:
- WB_BYPASS, 1: 1 = register file writes before it reads, so the WB entry is not compared; 0 = the WB entry is also compared.
- REG_W, 3: register-number width (8 GPRs).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- rs_num_in, in, REG_W: source reg 1 of the instruction in decode.
- rs_vld_in, in, 1: source reg 1 is read.
- rt_num_in, in, REG_W: source reg 2 of the instruction in decode.
- rt_vld_in, in, 1: source reg 2 is read.
- dst_reg_num_in, in, REG_W: destination reg of the instruction in decode.
- RegWriteEN_in, in, 1: instruction in decode writes a register.
- flush_in, in, 1: branch/jump resolved taken in EX; the instruction in decode is wrong-path.
- mem_stall_in, in, 1: memory stage busy; the whole pipe holds.
- pipe_stall_out, out, 1: hold PC and IF/ID.
- bubble_out, out, 1: force all ID/EX control fields to 0 (NOP).
- idex_en_out, out, 1: enable for the ID/EX register.
- stall_cnt_out, out, 16: hazard-stall cycle count (see Optional Feature).

Behaviour:
- State: sb_ex, sb_mem, sb_wb, each {vld, reg[REG_W-1:0]}. Reset clears all vld to 0 and reg to 0.
- match(r) = (sb_ex.vld & sb_ex.reg==r) | (sb_mem.vld & sb_mem.reg==r) | (WB_BYPASS==0 & sb_wb.vld & sb_wb.reg==r).
- hazard = (rs_vld_in & match(rs_num_in)) | (rt_vld_in & match(rt_num_in)). r0 is a normal register and gets no special case.
- Outputs are combinational from state and inputs. With reset asserted and inputs idle, all outputs are 0 except idex_en_out = 1.
- idex_en_out = ~mem_stall_in.
- pipe_stall_out = mem_stall_in | (hazard & ~flush_in).
- bubble_out = ~mem_stall_in & (hazard | flush_in).
- Clock edge with mem_stall_in=1: all entries hold, and flush_in is not acted on. EX is frozen, so flush_in stays asserted until mem_stall_in drops and is applied then.
- Clock edge with mem_stall_in=0:
  - sb_wb <= sb_mem; sb_mem <= sb_ex.
  - sb_ex <= bubble_out ? {0, 0} : {RegWriteEN_in, dst_reg_num_in}.
- Flush priority: flush_in overrides hazard; no stall is raised, and the wrong-path instruction is dropped and replaced by a bubble.
- The branch instruction already in EX keeps its scoreboard entry (a JAL writing r7 still blocks readers).
- Maximum consecutive hazard stalls for one instruction: 2 with WB_BYPASS=1, 3 with WB_BYPASS=0. The entry ages out by shifting, with no counter required.
- Back-to-back dependents: each new writer enters sb_ex only when not bubbled, so a stalled instruction never enters the scoreboard twice.
- Reset mid-stall: all entries are invalidated immediately (asynchronously); the next cycle's decode proceeds with no stall.
- Simultaneous hazard, flush and mem_stall: mem_stall dominates (hold, no bubble); then flush; then hazard.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined: 16-bit counter, reset 0. It increments on each clock edge where mem_stall_in=0, hazard=1 and flush_in=0, and saturates at 16'hFFFF (no wrap). It drives stall_cnt_out.
- Not defined: no counter flops are built; stall_cnt_out is tied to 16'h0000.

Test Plan:
- Independent stream: rs/rt never match any writer -> pipe_stall_out=0, bubble_out=0, idex_en_out=1 on every cycle.
- Writer r3 followed by reader of r3 (rs_vld=1), WB_BYPASS=1 -> 2 cycles pipe_stall_out=1 with bubble_out=1, then released on the 3rd cycle; stall_cnt_out=2 with HAZARD_STALL_CNT_EN.
- Same stimulus with WB_BYPASS=0 -> 3 stall cycles.
- Reader of r5 stalled by sb_ex={1,5} with mem_stall_in=1 for 4 cycles -> scoreboard holds, bubble_out=0, pipe_stall_out=1. After release the stall count resumes, for 2 hazard bubbles total.
- flush_in=1 while decode holds a writer of r2 that also hazards -> pipe_stall_out=0, bubble_out=1. Next cycle sb_ex.vld=0, and a reader of r2 then sees no stall.
- Assert rst during the 1st stall cycle of the r3 case -> all outputs return to idle values immediately; on deassert the reader of r3 passes with no stall; stall_cnt_out=0.
